vga_timing_gen: RTL and testbench



---
 rtl/vga_if.sv | 30 +++
 rtl/vga_timing_gen.sv | 143 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vga_if.sv
// Raster timing bundle from the timing generator to pixel/colour logic.
// rgb exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_if #(
  parameter int COORD_W = 10
);
  logic               hsync;
  logic               vsync;
  logic               de;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               line_start;
  logic               frame_start;
`ifdef VGA_TEST_PATTERN_EN
  logic [11:0]        rgb;
`endif

  modport master (
    output hsync, vsync, de, x, y, line_start, frame_start
`ifdef VGA_TEST_PATTERN_EN
    , output rgb
`endif
  );

  modport slave (
    input hsync, vsync, de, x, y, line_start, frame_start
`ifdef VGA_TEST_PATTERN_EN
    , input rgb
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator on the pixel clock, gated by a synchronised PLL lock.
// Define VGA_TEST_PATTERN_EN to add an eight-bar colour test pattern on rgb.
//
// state | meaning
// IDLE  | counters parked at (0,0), outputs at idle levels
// RUN   | counters hold a live raster position being decoded
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int COORD_W   = 10
) (
  input  logic  clk_25m,
  input  logic  reset_n,
  input  logic  locked,
  vga_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic               lock_meta;
  logic               run;
  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;

  logic               live;
  logic               de_nxt;
  logic               hs_nxt;
  logic               vs_nxt;

  // Output stage decodes the counters while they are live; RUN keeps it decoding
  // for one extra edge after lock loss so the last position is still reported.
  always_comb begin
    live   = run || (state == RUN);
    de_nxt = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hs_nxt = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_nxt = (v_cnt >= VS_START) && (v_cnt < VS_END);
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]  bar;
  logic [11:0] rgb_nxt;

  always_comb begin
    bar     = 3'(h_cnt / COORD_W'(H_ACTIVE / 8));
    rgb_nxt = 12'h000;
    if (de_nxt) begin
      case (bar)
        3'd0:    rgb_nxt = 12'hFFF;
        3'd1:    rgb_nxt = 12'hFF0;
        3'd2:    rgb_nxt = 12'h0FF;
        3'd3:    rgb_nxt = 12'h0F0;
        3'd4:    rgb_nxt = 12'hF0F;
        3'd5:    rgb_nxt = 12'hF00;
        3'd6:    rgb_nxt = 12'h00F;
        default: rgb_nxt = 12'h000;
      endcase
    end
  end
`endif

  always_ff @(posedge clk_25m or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta       <= 1'b0;
      run             <= 1'b0;
      state           <= IDLE;
      h_cnt           <= '0;
      v_cnt           <= '0;
      vga.hsync       <= ~HSYNC_POL;
      vga.vsync       <= ~VSYNC_POL;
      vga.de          <= 1'b0;
      vga.x           <= '0;
      vga.y           <= '0;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      vga.rgb         <= 12'h000;
`endif
    end else begin
      lock_meta <= locked;
      run       <= lock_meta;

      if (run) begin
        state <= RUN;
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + COORD_W'(1);
        end else begin
          h_cnt <= h_cnt + COORD_W'(1);
        end
      end else begin
        state <= IDLE;
        h_cnt <= '0;
        v_cnt <= '0;
      end

      if (live) begin
        vga.hsync       <= hs_nxt ? HSYNC_POL : ~HSYNC_POL;
        vga.vsync       <= vs_nxt ? VSYNC_POL : ~VSYNC_POL;
        vga.de          <= de_nxt;
        vga.x           <= h_cnt;
        vga.y           <= v_cnt;
        vga.line_start  <= (h_cnt == '0);
        vga.frame_start <= (h_cnt == '0) && (v_cnt == '0);
`ifdef VGA_TEST_PATTERN_EN
        vga.rgb         <= rgb_nxt;
`endif
      end else begin
        vga.hsync       <= ~HSYNC_POL;
        vga.vsync       <= ~VSYNC_POL;
        vga.de          <= 1'b0;
        vga.x           <= '0;
        vga.y           <= '0;
        vga.line_start  <= 1'b0;
        vga.frame_start <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
        vga.rgb         <= 12'h000;
`endif
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: standard 800-pixel lines with a shortened
// 12-line frame (6 visible, vsync on lines 8..9) so whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int HT = 800;
  localparam int VA = 6;
  localparam int VT = 12;

  logic clk_25m = 1'b0;
  logic reset_n = 1'b0;
  logic locked  = 1'b1;

  int total = 0;
  int bad   = 0;

  always #20 clk_25m = ~clk_25m;

  vga_if #(.COORD_W(10)) vga ();

  vga_timing_gen #(
    .V_ACTIVE(6),
    .V_FP    (2),
    .V_SYNC  (2),
    .V_BP    (2)
  ) dut (
    .clk_25m(clk_25m),
    .reset_n(reset_n),
    .locked (locked),
    .vga    (vga)
  );

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_25m);
    @(negedge clk_25m);
  endtask

  function automatic int exp_rgb(input int h, input int v);
    int bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    if (h >= 640 || v >= VA) return 0;
    return bars[h / 80];
  endfunction

  int h, v;
  int errs, rgb_errs, de_cnt, vs_cnt, hs_cnt, ls_cnt, fs_cnt;
  int rgb_0, rgb_80, rgb_639, rgb_640;

  initial begin
    // Reset with lock already present
    repeat (4) step();
    check("rst_hsync", vga.hsync, 1);
    check("rst_vsync", vga.vsync, 1);
    check("rst_de", vga.de, 0);
    check("rst_x", vga.x, 0);
    check("rst_y", vga.y, 0);
    check("rst_line_start", vga.line_start, 0);
    check("rst_frame_start", vga.frame_start, 0);

    reset_n = 1'b1;
    step();
    check("rel1_frame_start", vga.frame_start, 0);
    step();
    check("rel2_de", vga.de, 0);
    step();
    check("rel3_frame_start", vga.frame_start, 1);
    check("rel3_de", vga.de, 1);
    check("rel3_x", vga.x, 0);
    check("rel3_y", vga.y, 0);
    check("rel3_line_start", vga.line_start, 1);

    // One full frame against the per-cycle raster model
    errs = 0; rgb_errs = 0; de_cnt = 0; vs_cnt = 0; hs_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    rgb_0 = -1; rgb_80 = -1; rgb_639 = -1; rgb_640 = -1;
    for (int i = 0; i < HT * VT; i++) begin
      h = i % HT;
      v = i / HT;
      if (vga.x !== 10'(h) || vga.y !== 10'(v)) errs++;
      if (vga.de !== ((h < 640) && (v < VA))) errs++;
      if (vga.hsync !== !((h >= 656) && (h < 752))) errs++;
      if (vga.vsync !== !((v >= 8) && (v < 10))) errs++;
      if (vga.line_start !== (h == 0)) errs++;
      if (vga.frame_start !== (i == 0)) errs++;
      if (vga.de === 1'b1) de_cnt++;
      if (vga.vsync === 1'b0) vs_cnt++;
      if (vga.hsync === 1'b0) hs_cnt++;
      if (vga.line_start === 1'b1) ls_cnt++;
      if (vga.frame_start === 1'b1) fs_cnt++;
`ifdef VGA_TEST_PATTERN_EN
      if (vga.rgb !== 12'(exp_rgb(h, v))) rgb_errs++;
      if (v == 1 && h == 0) rgb_0 = int'(vga.rgb);
      if (v == 1 && h == 80) rgb_80 = int'(vga.rgb);
      if (v == 1 && h == 639) rgb_639 = int'(vga.rgb);
      if (v == 1 && h == 640) rgb_640 = int'(vga.rgb);
`endif
      step();
    end
    check("frame_cycle_errs", errs, 0);
    check("frame_de_cycles", de_cnt, VA * 640);
    check("frame_vsync_cycles", vs_cnt, 1600);
    check("frame_hsync_cycles", hs_cnt, 96 * VT);
    check("frame_line_starts", ls_cnt, VT);
    check("frame_frame_starts", fs_cnt, 1);
    check("wrap_y", vga.y, 0);
    check("wrap_x", vga.x, 0);
    check("wrap_frame_start", vga.frame_start, 1);
`ifdef VGA_TEST_PATTERN_EN
    check("rgb_errs", rgb_errs, 0);
    check("rgb_bar0", rgb_0, 12'hFFF);
    check("rgb_bar1", rgb_80, 12'hFF0);
    check("rgb_bar7", rgb_639, 12'h000);
    check("rgb_blank", rgb_640, 12'h000);
`endif

    // Drop lock mid-frame at (300,3)
    repeat (3 * HT + 300) step();
    check("drop_x", vga.x, 300);
    check("drop_y", vga.y, 3);
    locked = 1'b0;
    step();
    check("drop1_x", vga.x, 301);
    step();
    check("drop2_x", vga.x, 302);
    step();
    check("drop3_x", vga.x, 303);
    check("drop3_de", vga.de, 1);
    step();
    check("drop4_x", vga.x, 0);
    check("drop4_y", vga.y, 0);
    check("drop4_de", vga.de, 0);
    check("drop4_hsync", vga.hsync, 1);

    // Lock held low: raster must stay idle
    errs = 0; fs_cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      if (vga.de !== 1'b0 || vga.x !== 10'd0 || vga.y !== 10'd0) errs++;
      if (vga.hsync !== 1'b1 || vga.vsync !== 1'b1 || vga.line_start !== 1'b0) errs++;
      if (vga.frame_start === 1'b1) fs_cnt++;
      step();
    end
    check("idle_errs", errs, 0);
    check("idle_frame_starts", fs_cnt, 0);

    // Lock returns: restart at (0,0)
    locked = 1'b1;
    step();
    check("relock1_frame_start", vga.frame_start, 0);
    step();
    check("relock2_de", vga.de, 0);
    step();
    check("relock3_frame_start", vga.frame_start, 1);
    check("relock3_de", vga.de, 1);
    check("relock3_x", vga.x, 0);
    check("relock3_y", vga.y, 0);
    step();
    check("relock4_x", vga.x, 1);
    check("relock4_frame_start", vga.frame_start, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
